// File: rtl/fx2_stream_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fx2_pkg
// Purpose  : Shared types and constants for the FX2 slave-FIFO stream path:
//            controller state encoding, endpoint FIFOADR codes, packet size.
// Revision : 1.0 - initial release
// ============================================================================
package fx2_pkg;

  // Controller states: idle, streaming words, committing a short packet
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // FIFOADR codes selecting the FX2 endpoint buffers
  localparam logic [1:0] EP2_ADDR = 2'b00;
  localparam logic [1:0] EP4_ADDR = 2'b01;
  localparam logic [1:0] EP6_ADDR = 2'b10;
  localparam logic [1:0] EP8_ADDR = 2'b11;

  // 16-bit words per full high-speed bulk packet (512 bytes)
  localparam int DEFAULT_PKT_WORDS = 256;

endpackage
`default_nettype wire

// File: rtl/fx2_stream_ctrl_iq_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module   : iq_pair_fifo
// Purpose  : Synchronous show-ahead FIFO holding packed {I,Q} pairs.
//            Depth is 2**AW; pushes when full and pops when empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module iq_pair_fifo #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Advance pointers on accepted push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/fx2_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fx2_stream_ctrl
// Purpose  : Streams DDC I/Q pairs into the FX2 slave FIFO (sync, write-only)
//            as I-then-Q 16-bit words under FLAGB flow control, committing
//            partial packets with PKTEND after an idle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module fx2_stream_ctrl
  import fx2_pkg::*;
#(
  parameter int         FIFO_AW       = 4,
  parameter int         PKT_WORDS     = DEFAULT_PKT_WORDS,
  parameter int         FLUSH_TIMEOUT = 1024,
  parameter logic [1:0] EP_ADDR       = EP6_ADDR
) (
  input  logic        ADC_CLK,
  input  logic        RST,
  input  logic        enable,
  input  logic        iq_valid,
  input  logic [15:0] i_data,
  input  logic [15:0] q_data,
  input  logic        flag_full_n,
  output logic [15:0] fd,
  output logic        fd_oe,
  output logic        slwr_n,
  output logic        slrd_n,
  output logic        sloe_n,
  output logic        slcs_n,
  output logic [1:0]  fifoadr,
  output logic        pktend_n,
  output logic [15:0] overflow_cnt,
  output logic        busy
);

  localparam int WC_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int IC_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [WC_W-1:0] WC_LAST  = WC_W'(PKT_WORDS - 1);
  localparam logic [IC_W-1:0] IC_MAX   = IC_W'(FLUSH_TIMEOUT);
  localparam bit              FLUSH_EN = (FLUSH_TIMEOUT > 0);

  state_t          state;
  state_t          state_nx;
  logic            flag_q;
  logic            phase;      // 0: next word is I, 1: next word is Q
  logic [WC_W-1:0] word_cnt;
  logic [IC_W-1:0] idle_cnt;

  logic            fifo_full;
  logic            fifo_empty;
  logic [31:0]     fifo_dout;
  logic            push;
  logic            drop;
  logic            pop;
  logic            wr_go;
  logic            flush_go;

  // A pair is only ever accepted whole; when full it is counted as dropped
  assign push  = enable & iq_valid & ~fifo_full;
  assign drop  = enable & iq_valid &  fifo_full;
  // Flag is one cycle stale; firmware margin on FLAGB covers the lag
  assign wr_go = ~fifo_empty & flag_q & (state != ST_FLUSH);
  // The pair leaves the FIFO only once its Q word has gone out
  assign pop   = wr_go & phase;

  iq_pair_fifo #(
    .AW (FIFO_AW),
    .DW (32)
  ) u_fifo (
    .clk   (ADC_CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   ({i_data, q_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state logic: stream while data flows, flush stale partial packets
  always_comb begin
    state_nx = state;
    flush_go = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_go) begin
          state_nx = ST_WRITE;
        end else if (FLUSH_EN && (idle_cnt == IC_MAX) && (word_cnt != '0) &&
                     !phase && flag_q) begin
          state_nx = ST_FLUSH;
          flush_go = 1'b1;
        end
      end
      ST_WRITE: if (fifo_empty && !phase) state_nx = ST_IDLE;
      ST_FLUSH: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // State register and registered flag sample
  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      flag_q <= 1'b0;
    end else begin
      state  <= state_nx;
      flag_q <= flag_full_n;
    end
  end

  // Pin drivers and word sequencing; PKTEND only asserts in FLUSH where no write occurs
  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      slwr_n   <= 1'b1;
      pktend_n <= 1'b1;
      fd       <= '0;
      fd_oe    <= 1'b0;
      phase    <= 1'b0;
      word_cnt <= '0;
    end else begin
      fd_oe    <= 1'b1;
      pktend_n <= ~flush_go;
      if (wr_go) begin
        slwr_n   <= 1'b0;
        fd       <= phase ? fifo_dout[15:0] : fifo_dout[31:16];
        phase    <= ~phase;
        word_cnt <= (word_cnt == WC_LAST) ? '0 : word_cnt + 1'b1;
      end else begin
        slwr_n <= 1'b1;
        if (flush_go) word_cnt <= '0;
      end
    end
  end

  // Idle timer: runs only while idle with nothing queued, saturates at the timeout
  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      idle_cnt <= '0;
    end else if (wr_go || push) begin
      idle_cnt <= '0;
    end else if ((state == ST_IDLE) && fifo_empty && (idle_cnt != IC_MAX)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Saturating count of pairs dropped on a full FIFO
  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      overflow_cnt <= '0;
    end else if (drop && (overflow_cnt != 16'hFFFF)) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  assign slrd_n  = 1'b1;
  assign sloe_n  = 1'b1;
  assign slcs_n  = 1'b0;
  assign fifoadr = EP_ADDR;
  assign busy    = ~fifo_empty | phase;

endmodule
`default_nettype wire

// File: doc/fx2_stream_ctrl.md
Name: fx2_stream_ctrl

Overview:
- Sequences DDC I/Q output pairs into the FX2 slave FIFO (synchronous mode, write-only) toward the IN endpoint.
- Buffers pairs in a small FIFO and emits I then Q as 16-bit words under FLAGB flow control.
- Commits short packets with PKTEND after an idle timeout.
- Sits between the DDC and the FD/SLWR/FIFOADR pins of main; one clock domain, ADC_CLK, which also sources FX2_IFCLK.

Parameters:
- FIFO_AW, 4: log2 of pair FIFO depth (16 pairs).
- PKT_WORDS, 256: words per FX2 packet (512 bytes); FX2 auto-commits full packets.
- FLUSH_TIMEOUT, 1024: idle cycles before a partial packet is committed; 0 disables flush.
- EP_ADDR, 2'b10: FIFOADR value (EP6).

Ports:
- ADC_CLK, in, 1: sole clock, rising edge.
- RST, in, 1: synchronous, active-high reset.
- enable, in, 1: accept new pairs when high.
- iq_valid, in, 1: pair strobe from DDC.
- i_data, in, 16: I sample, two's complement.
- q_data, in, 16: Q sample, two's complement.
- flag_full_n, in, 1: FX2_FLAGB, programmable-full, active low.
- fd, out, 16: FD write data.
- fd_oe, out, 1: FD output enable for top-level tristate.
- slwr_n, out, 1: FX2_SLWR.
- slrd_n, out, 1: FX2_SLRD, constant 1.
- sloe_n, out, 1: FX2_SLOE, constant 1.
- slcs_n, out, 1: FX2_SLCS, constant 0.
- fifoadr, out, 2: constant EP_ADDR.
- pktend_n, out, 1: FX2_PKTEND.
- overflow_cnt, out, 16: dropped pairs, saturating.
- busy, out, 1: FIFO non-empty, or a pair is half-written.

Behaviour:
- Reset, sampled on the ADC_CLK edge:
  - slwr_n=1, pktend_n=1, fd=0, fd_oe=0.
  - FIFO pointers, phase, word_cnt, idle_cnt and overflow_cnt are cleared; state=IDLE.
  - Constant outputs hold their stated values in and out of reset.
  - fd_oe=1 from the first cycle after reset.
- All pin outputs are registered. flag_full_n is registered once (flag_q).
- FX2 firmware sets FLAGB with at least 2 words of margin so that the 1-cycle flag lag cannot overrun.
- Input side:
  - enable & iq_valid & FIFO not full: {i_data, q_data} is pushed at that edge.
  - enable & iq_valid & FIFO full: the pair is dropped and overflow_cnt increments (saturates at 0xFFFF). Words are never split.
  - enable low: inputs are ignored; the FIFO still drains and flush still operates.
- Write rule, evaluated each cycle: wr_go = FIFO non-empty & flag_q & state != FLUSH.
  - wr_go: at the next edge slwr_n=0 and fd = phase ? Q : I; phase toggles. When phase was 1, the pair is popped.
  - Otherwise slwr_n=1 and fd holds its value.
- Latency: pair pushed at edge N → I driven with slwr_n=0 after edge N+1, Q after edge N+2 (flag_q high throughout). Back-to-back pairs stream at one word per cycle.
- flag_q low between I and Q: phase is preserved, and Q is written first once flag_q returns high.
- word_cnt: incremented per written word, wraps to 0 at PKT_WORDS.
- FSM states:
  - IDLE → WRITE on wr_go.
  - WRITE → IDLE when the FIFO is empty and phase=0.
  - IDLE → FLUSH when idle_cnt==FLUSH_TIMEOUT & word_cnt!=0 & phase=0 & flag_q.
  - FLUSH: pktend_n=0 for exactly one cycle, word_cnt←0, then IDLE. slwr_n stays 1 in FLUSH; pktend_n and slwr_n are never low together.
- idle_cnt: counts cycles in IDLE with an empty FIFO; cleared on any write or push, saturates at FLUSH_TIMEOUT.
- A pair pushed during the FLUSH cycle is queued and written starting the following cycle.
- RST mid-pair: the half-written pair is abandoned. The next stream starts with I, and word_cnt restarts at 0.

Decomposition:
- Package fx2_pkg: FSM state encoding (IDLE, WRITE, FLUSH), EP address constants (EP2/4/6/8), default PKT_WORDS.
- Sub-module iq_pair_fifo: synchronous 32-bit FIFO, depth 2^FIFO_AW, with full, empty, push and pop. This is the only sub-module.

Test Plan:
- Reset: RST for 3 cycles → slwr_n=1, pktend_n=1, fifoadr=2'b10, slcs_n=0, sloe_n=1, slrd_n=1, overflow_cnt=0, fd_oe=0 then 1.
- Single pair I=0x0FA0, Q=0xF060, flag high → two consecutive slwr_n=0 cycles with fd=0x0FA0 then 0xF060; first write one cycle after the push edge.
- Flag stall: flag_full_n low for 5 cycles right after the I word → slwr_n stays 1 through the stall; Q written on the second cycle after flag returns high.
- Overflow, FIFO_AW=4: flag low, 17 pairs pushed → overflow_cnt=1. Release flag → exactly 32 words written, first 16 pairs in order.
- Flush, FLUSH_TIMEOUT=8: 3 pairs then idle → pktend_n low for exactly one cycle, 8 idle cycles after the last write. Repeat with 128 pairs (256 words) → no pktend.
- Reset mid-pair: RST asserted the cycle after the I word → Q is never written; the next pair begins with its I word and busy=0 right after reset.
